// File: rtl/cmu_ctrl_pkg.sv
// cmu_ctrl_pkg
//   Shared definitions for the clock management unit: the controller state
//   encoding and a small decode helper used by the top level.
//   Optional feature macro (used by cmu_ctrl): CMU_WATCHDOG_EN.
//   No ports; imported with "import cmu_ctrl_pkg::*;".

package cmu_ctrl_pkg;

  // HALT is encoded as all-zero so a cleared state register means "stopped".
  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CYCLE = 2'b10,
    ST_STEP  = 2'b11
  } cmu_state_t;

  // Every state except HALT drives the core clock enable.
  function automatic logic is_running(input cmu_state_t s);
    return s != ST_HALT;
  endfunction

endpackage

// File: rtl/cmu_ctrl_wdog.sv
// cmu_wdog
//   Stall watchdog for the clock management unit. Counts enabled clocks since
//   the last retired instruction or state change and requests a halt when
//   WDOG_CYCLES enabled clocks pass without progress. Built only when the
//   macro CMU_WATCHDOG_EN is defined.
// Ports
//   clk        in   system clock
//   rst_n      in   async active-low reset
//   enable     in   registered core clock enable (counts only enabled clocks)
//   cycle_done in   qualified instruction retire (cycle_end & enable)
//   state_chg  in   controller changes state on this edge
//   armed      in   controller is in a state the watchdog may stop (RUN/STEP)
//   accept     in   controller leaves HALT on this edge (clears the flag)
//   hit        out  combinational halt request for this clock
//   fire       out  registered sticky watchdog flag

module cmu_wdog #(
  parameter int unsigned WDOG_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic cycle_done,
  input  logic state_chg,
  input  logic armed,
  input  logic accept,
  output logic hit,
  output logic fire
);

  localparam int unsigned CW = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);

  logic [CW-1:0] count;

  // The request fires on the enabled clock that would be the WDOG_CYCLES-th
  // one without a retire, so the core sees exactly WDOG_CYCLES enabled clocks.
  assign hit = armed & enable & ~cycle_done & (count == LAST);

  // Progress or any state change restarts the window; the count saturates
  // so a one-clock CYCLE visit can never wrap it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (state_chg || cycle_done) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  // Sticky until the controller is explicitly restarted out of HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire <= 1'b0;
    end else if (hit) begin
      fire <= 1'b1;
    end else if (accept) begin
      fire <= 1'b0;
    end
  end

endmodule

// File: rtl/cmu_ctrl.sv
// cmu_ctrl
//   Clock management unit driving the core clock enable. Modes: free run,
//   halt, single clock and N-instruction step burst. Latches the halt cause
//   from N_HALT_SRC sources and pulses debug_trig on every entry to HALT.
//   Optional feature: define CMU_WATCHDOG_EN to add the stall watchdog
//   (cmu_wdog); otherwise wdog_fire is tied low.
// Ports
//   clk           in   system clock
//   rst_n         in   async active-low reset
//   cycle_end     in   instruction retire pulse, valid while clk_enable=1
//   trig_halt     in   [N_HALT_SRC] one-clock halt pulses
//   trig_unhalt   in   one-clock pulse HALT -> RUN
//   trig_cycle    in   one-clock pulse, one enabled clock
//   trig_step     in   one-clock pulse, run step_count instructions
//   step_count    in   [STEP_CNT_W] burst length (0 behaves as 1)
//   clock_supress in   debug busy, blocks leaving HALT
//   clk_enable    out  registered core clock enable
//   halted        out  registered, high while in HALT
//   debug_trig    out  one-clock pulse on entry to HALT
//   halt_cause    out  [N_HALT_SRC] sources seen during the current halt
//   wdog_fire     out  sticky watchdog flag

import cmu_ctrl_pkg::*;

module cmu_ctrl #(
  parameter int unsigned N_HALT_SRC   = 4,
  parameter int unsigned STEP_CNT_W   = 16,
  parameter bit          RESET_HALTED = 1'b1,
  parameter int unsigned WDOG_CYCLES  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cycle_end,
  input  logic [N_HALT_SRC-1:0] trig_halt,
  input  logic                  trig_unhalt,
  input  logic                  trig_cycle,
  input  logic                  trig_step,
  input  logic [STEP_CNT_W-1:0] step_count,
  input  logic                  clock_supress,
  output logic                  clk_enable,
  output logic                  halted,
  output logic                  debug_trig,
  output logic [N_HALT_SRC-1:0] halt_cause,
  output logic                  wdog_fire
);

  localparam cmu_state_t RESET_STATE = RESET_HALTED ? ST_HALT : ST_RUN;

  cmu_state_t            state, state_next;
  logic [STEP_CNT_W-1:0] cnt, cnt_next;
  logic [N_HALT_SRC-1:0] cause_next;
  logic                  dbg_next;
  logic                  any_halt;
  logic                  cycle_done;
  logic                  wdog_hit;

  assign any_halt   = |trig_halt;
  assign cycle_done = cycle_end & clk_enable;

`ifdef CMU_WATCHDOG_EN
  cmu_wdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (clk_enable),
    .cycle_done (cycle_done),
    .state_chg  (state_next != state),
    .armed      ((state == ST_RUN) || (state == ST_STEP)),
    .accept     ((state == ST_HALT) && (state_next != ST_HALT)),
    .hit        (wdog_hit),
    .fire       (wdog_fire)
  );
`else
  // The parameter stays referenced so both builds share one interface.
  assign wdog_hit  = 1'b0 & (WDOG_CYCLES != 0);
  assign wdog_fire = 1'b0;
`endif

  // Next-state logic. Halt triggers always win; in HALT the remaining
  // triggers are checked unhalt > step > cycle and only while the debug side
  // is idle. Anything not taken this clock is simply dropped.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cause_next = halt_cause;
    dbg_next   = 1'b0;

    unique case (state)
      ST_HALT: begin
        if (any_halt) begin
          cause_next = halt_cause | trig_halt;
        end else if (!clock_supress) begin
          if (trig_unhalt) begin
            state_next = ST_RUN;
          end else if (trig_step) begin
            state_next = ST_STEP;
            cnt_next   = (step_count == '0) ? STEP_CNT_W'(1) : step_count;
          end else if (trig_cycle) begin
            state_next = ST_CYCLE;
          end
        end
      end
      ST_RUN: begin
        if (any_halt || wdog_hit) begin
          state_next = ST_HALT;
        end
      end
      ST_CYCLE: begin
        state_next = ST_HALT;
      end
      ST_STEP: begin
        if (any_halt || wdog_hit) begin
          state_next = ST_HALT;
          cnt_next   = '0;
        end else if (cycle_done) begin
          cnt_next = cnt - STEP_CNT_W'(1);
          if (cnt == STEP_CNT_W'(1)) begin
            state_next = ST_HALT;
          end
        end
      end
      default: state_next = ST_HALT;
    endcase

    // Entry to HALT restarts the cause latch with this clock's sources (so a
    // halt coinciding with burst completion is still recorded); leaving HALT
    // wipes it.
    if (state != ST_HALT && state_next == ST_HALT) begin
      dbg_next   = 1'b1;
      cause_next = trig_halt;
    end else if (state == ST_HALT && state_next != ST_HALT) begin
      cause_next = '0;
    end
  end

  // All outputs are flops fed from the next state so a transition on an
  // edge is visible on clk_enable right after that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RESET_STATE;
      cnt        <= '0;
      halt_cause <= '0;
      debug_trig <= 1'b0;
      clk_enable <= !RESET_HALTED;
      halted     <= RESET_HALTED;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      halt_cause <= cause_next;
      debug_trig <= dbg_next;
      clk_enable <= is_running(state_next);
      halted     <= (state_next == ST_HALT);
    end
  end

endmodule

// File: tb/tb_cmu_ctrl.sv
// tb_cmu_ctrl
//   Self-checking bench for cmu_ctrl (RESET_HALTED=1, 4 halt sources). A
//   table of one-clock input vectors with hand-derived expected outputs is
//   replayed through a scoreboard queue, followed by hand-written sequences
//   for the watchdog / long burst and an asynchronous reset mid-operation.
//   Define CMU_WATCHDOG_EN to build the watchdog variant (WDOG_CYCLES=8).

module tb_cmu_ctrl;

  localparam int N  = 4;
  localparam int SW = 16;
`ifdef CMU_WATCHDOG_EN
  localparam int WD = 8;
`else
  localparam int WD = 256;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cycle_end = 1'b0;
  logic [N-1:0]  trig_halt = '0;
  logic          trig_unhalt = 1'b0;
  logic          trig_cycle = 1'b0;
  logic          trig_step = 1'b0;
  logic [SW-1:0] step_count = '0;
  logic          clock_supress = 1'b0;
  logic          clk_enable;
  logic          halted;
  logic          debug_trig;
  logic [N-1:0]  halt_cause;
  logic          wdog_fire;

  int n_checks = 0;
  int n_errors = 0;

  cmu_ctrl #(
    .N_HALT_SRC   (N),
    .STEP_CNT_W   (SW),
    .RESET_HALTED (1'b1),
    .WDOG_CYCLES  (WD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cycle_end     (cycle_end),
    .trig_halt     (trig_halt),
    .trig_unhalt   (trig_unhalt),
    .trig_cycle    (trig_cycle),
    .trig_step     (trig_step),
    .step_count    (step_count),
    .clock_supress (clock_supress),
    .clk_enable    (clk_enable),
    .halted        (halted),
    .debug_trig    (debug_trig),
    .halt_cause    (halt_cause),
    .wdog_fire     (wdog_fire)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  th;
    logic          un, cy, st;
    logic [SW-1:0] sc;
    logic          sup, ce;
    logic          e_en, e_hl, e_dt;
    logic [N-1:0]  e_hc;
  } vec_t;

  typedef struct {
    logic         en, hl, dt, wf;
    logic [N-1:0] hc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic addVec(input logic [N-1:0] th, input logic un, cy, st,
                        input logic [SW-1:0] sc, input logic sup, ce,
                        input logic e_en, e_hl, e_dt, input logic [N-1:0] e_hc);
    vec_t v;
    v.th = th; v.un = un; v.cy = cy; v.st = st; v.sc = sc; v.sup = sup; v.ce = ce;
    v.e_en = e_en; v.e_hl = e_hl; v.e_dt = e_dt; v.e_hc = e_hc;
    vecs.push_back(v);
  endtask

  task automatic driveInputs(input logic [N-1:0] th, input logic un, cy, st,
                             input logic [SW-1:0] sc, input logic sup, ce);
    trig_halt = th; trig_unhalt = un; trig_cycle = cy; trig_step = st;
    step_count = sc; clock_supress = sup; cycle_end = ce;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    driveInputs(v.th, v.un, v.cy, v.st, v.sc, v.sup, v.ce);
    e.en = v.e_en; e.hl = v.e_hl; e.dt = v.e_dt; e.hc = v.e_hc; e.wf = 1'b0;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compareRow(input int idx);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput($sformatf("row%0d scoreboard_empty", idx), 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    checkOutput($sformatf("row%0d clk_enable", idx), 32'(clk_enable), 32'(e.en));
    checkOutput($sformatf("row%0d halted", idx),     32'(halted),     32'(e.hl));
    checkOutput($sformatf("row%0d debug_trig", idx), 32'(debug_trig), 32'(e.dt));
    checkOutput($sformatf("row%0d halt_cause", idx), 32'(halt_cause), 32'(e.hc));
    checkOutput($sformatf("row%0d wdog_fire", idx),  32'(wdog_fire),  32'(e.wf));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n_en;

    //      th       un cy st sc     sup ce   en hl dt hc
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 0,   0, 1, 0, 4'b0000);
    addVec(4'b0000, 1, 0, 0, 16'd0, 0, 0,   1, 0, 0, 4'b0000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 0,   1, 0, 0, 4'b0000);
    addVec(4'b0010, 0, 0, 0, 16'd0, 0, 0,   0, 1, 1, 4'b0010);
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 0,   0, 1, 0, 4'b0010);
    addVec(4'b1000, 0, 0, 0, 16'd0, 0, 0,   0, 1, 0, 4'b1010);
    addVec(4'b0000, 0, 1, 0, 16'd0, 0, 0,   1, 0, 0, 4'b0000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 0,   0, 1, 1, 4'b0000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 0,   0, 1, 0, 4'b0000);
    addVec(4'b0000, 0, 1, 0, 16'd0, 1, 0,   0, 1, 0, 4'b0000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 1, 0,   0, 1, 0, 4'b0000);
    addVec(4'b0000, 1, 0, 0, 16'd0, 1, 0,   0, 1, 0, 4'b0000);
    addVec(4'b0000, 0, 0, 1, 16'd3, 0, 0,   1, 0, 0, 4'b0000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 1,   1, 0, 0, 4'b0000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 0,   1, 0, 0, 4'b0000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 1,   1, 0, 0, 4'b0000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 1,   0, 1, 1, 4'b0000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 0,   0, 1, 0, 4'b0000);
    addVec(4'b0000, 0, 0, 1, 16'd0, 0, 0,   1, 0, 0, 4'b0000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 1,   0, 1, 1, 4'b0000);
    addVec(4'b0000, 0, 0, 1, 16'd5, 0, 0,   1, 0, 0, 4'b0000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 1,   1, 0, 0, 4'b0000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 1,   1, 0, 0, 4'b0000);
    addVec(4'b0001, 0, 0, 0, 16'd0, 0, 0,   0, 1, 1, 4'b0001);
    addVec(4'b0000, 1, 0, 1, 16'd2, 0, 0,   1, 0, 0, 4'b0000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 1,   1, 0, 0, 4'b0000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 1,   1, 0, 0, 4'b0000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 1,   1, 0, 0, 4'b0000);
    addVec(4'b0100, 1, 0, 0, 16'd0, 0, 0,   0, 1, 1, 4'b0100);
    addVec(4'b0001, 1, 0, 0, 16'd0, 0, 0,   0, 1, 0, 4'b0101);
    addVec(4'b0000, 0, 1, 1, 16'd4, 0, 0,   1, 0, 0, 4'b0000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 0,   1, 0, 0, 4'b0000);
    addVec(4'b0010, 0, 0, 0, 16'd0, 0, 1,   0, 1, 1, 4'b0010);
    addVec(4'b0000, 0, 0, 1, 16'd1, 0, 0,   1, 0, 0, 4'b0000);
    addVec(4'b1000, 0, 0, 0, 16'd0, 0, 1,   0, 1, 1, 4'b1000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 0,   0, 1, 0, 4'b1000);
    addVec(4'b0000, 1, 0, 0, 16'd0, 0, 0,   1, 0, 0, 4'b0000);
    addVec(4'b0000, 0, 1, 0, 16'd0, 0, 1,   1, 0, 0, 4'b0000);
    addVec(4'b1111, 0, 0, 0, 16'd0, 0, 0,   0, 1, 1, 4'b1111);
    addVec(4'b0000, 0, 1, 0, 16'd0, 0, 0,   1, 0, 0, 4'b0000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 0, 1,   0, 1, 1, 4'b0000);
    addVec(4'b0000, 1, 0, 0, 16'd0, 0, 0,   1, 0, 0, 4'b0000);
    addVec(4'b0000, 0, 0, 0, 16'd0, 1, 0,   1, 0, 0, 4'b0000);
    addVec(4'b0001, 0, 0, 0, 16'd0, 1, 0,   0, 1, 1, 4'b0001);

    // Reset values, applied with a real falling edge of rst_n.
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset clk_enable", 32'(clk_enable), 32'd0);
    checkOutput("reset halted",     32'(halted),     32'd1);
    checkOutput("reset debug_trig", 32'(debug_trig), 32'd0);
    checkOutput("reset halt_cause", 32'(halt_cause), 32'd0);
    checkOutput("reset wdog_fire",  32'(wdog_fire),  32'd0);
    #9 rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      tick();
      compareRow(i);
    end
    driveInputs('0, 0, 0, 0, '0, 0, 0);

    // Long burst with no retire: watchdog stops it, or it runs on forever.
    driveInputs('0, 0, 0, 1, 16'd5, 0, 0);
    tick();
    driveInputs('0, 0, 0, 0, '0, 0, 0);
`ifdef CMU_WATCHDOG_EN
    n_en = 0;
    while (clk_enable && n_en < 150) begin
      n_en++;
      tick();
    end
    checkOutput("wdog step enabled_clocks", 32'(n_en), 32'd8);
    checkOutput("wdog step halted",     32'(halted),     32'd1);
    checkOutput("wdog step wdog_fire",  32'(wdog_fire),  32'd1);
    checkOutput("wdog step debug_trig", 32'(debug_trig), 32'd1);
    checkOutput("wdog step halt_cause", 32'(halt_cause), 32'd0);
    driveInputs('0, 1, 0, 0, '0, 0, 0);
    tick();
    driveInputs('0, 0, 0, 0, '0, 0, 0);
    checkOutput("wdog unhalt wdog_fire", 32'(wdog_fire), 32'd0);
    checkOutput("wdog unhalt clk_enable", 32'(clk_enable), 32'd1);
    for (int i = 0; i < 20; i++) begin
      cycle_end = (i % 3 == 0);
      tick();
    end
    cycle_end = 1'b0;
    checkOutput("wdog run fed clk_enable", 32'(clk_enable), 32'd1);
    n_en = 0;
    while (clk_enable && n_en < 150) begin
      n_en++;
      tick();
    end
    checkOutput("wdog run bounded", 32'(n_en <= 8), 32'd1);
    checkOutput("wdog run wdog_fire", 32'(wdog_fire), 32'd1);
    checkOutput("wdog run halted", 32'(halted), 32'd1);
`else
    n_en = 0;
    for (int i = 0; i < 100; i++) begin
      if (clk_enable) n_en++;
      tick();
    end
    checkOutput("long step enabled_clocks", 32'(n_en), 32'd100);
    checkOutput("long step halted",    32'(halted),    32'd0);
    checkOutput("long step wdog_fire", 32'(wdog_fire), 32'd0);
    driveInputs(4'b0001, 0, 0, 0, '0, 0, 0);
    tick();
    driveInputs('0, 0, 0, 0, '0, 0, 0);
    checkOutput("long step abort halted", 32'(halted), 32'd1);
`endif

    // Asynchronous reset while debug_trig and halt_cause are live.
    driveInputs('0, 1, 0, 0, '0, 0, 0);
    tick();
    driveInputs(4'b0110, 0, 0, 0, '0, 0, 0);
    tick();
    driveInputs('0, 0, 0, 0, '0, 0, 0);
    checkOutput("pre-reset halt_cause", 32'(halt_cause), 32'h6);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset clk_enable", 32'(clk_enable), 32'd0);
    checkOutput("async reset halted",     32'(halted),     32'd1);
    checkOutput("async reset debug_trig", 32'(debug_trig), 32'd0);
    checkOutput("async reset halt_cause", 32'(halt_cause), 32'd0);
    checkOutput("async reset wdog_fire",  32'(wdog_fire),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    driveInputs('0, 1, 0, 0, '0, 0, 0);
    tick();
    driveInputs('0, 0, 0, 0, '0, 0, 0);
    checkOutput("post-reset unhalt clk_enable", 32'(clk_enable), 32'd1);
    checkOutput("post-reset unhalt halted",     32'(halted),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
